fib_sweep: RTL and testbench
============================

FIB_SWEEP -- requirements
Module: fib_sweep

Interface
REQ-001 Parameter INPUT_WIDTH, default 6, SHALL set the width of n_first, n_last, fib_n and out_n.
REQ-002 Parameter OUTPUT_WIDTH, default 16, SHALL set the width of fib_result and out_result.
REQ-003 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 start  in  1  request a sweep; sampled only in IDLE.
REQ-006 n_first, n_last  in  INPUT_WIDTH  inclusive sweep bounds; captured when start is accepted.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 fib_go  out  1  one-cycle start pulse to the downstream Fibonacci core.
REQ-009 fib_n  out  INPUT_WIDTH  index presented to the core; stable from fib_go until capture.
REQ-010 fib_result  in  OUTPUT_WIDTH  core result.
REQ-011 fib_overflow  in  1  core overflow flag.
REQ-012 fib_done  in  1  core done; level signal that stays high until the next go and clears one cycle after it.
REQ-013 out_valid / out_ready  out / in  1 / 1  result stream handshake; a transfer occurs when both are high on a rising edge.
REQ-014 out_n, out_result, out_overflow  out  INPUT_WIDTH, OUTPUT_WIDTH, 1  payload of the current stream beat.
REQ-015 sweep_done  out  1  one-cycle pulse when a sweep completes.
REQ-016 sweep_overflow  out  1  OR of out_overflow over the completed sweep; valid while sweep_done is high; holds its value until the next start.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, ISSUE, SETTLE, WAIT, EMIT and FINISH.
REQ-018 IDLE with start=1: latch the bounds, set idx=n_first, clear the overflow accumulator; go to FINISH if n_first>n_last, otherwise go to ISSUE.
REQ-019 ISSUE SHALL drive fib_go=1 and fib_n=idx for exactly one cycle, then go to SETTLE.
REQ-020 SETTLE SHALL ignore fib_done for one cycle, so that stale done from the previous request is never captured, then go to WAIT.
REQ-021 WAIT with fib_done=1: register fib_result, fib_overflow and idx into the out_* registers, set out_valid=1 and go to EMIT; with fib_done=0, remain in WAIT with no timeout.
REQ-022 EMIT: out_valid and the payload SHALL hold unchanged until out_ready=1.
REQ-023 On the EMIT transfer cycle: OR out_overflow into the accumulator and drop out_valid next cycle; go to FINISH if idx==n_last, otherwise increment idx and go to ISSUE.
REQ-024 FINISH SHALL assert sweep_done for one cycle, update sweep_overflow, then go to IDLE.
REQ-025 The idx comparison SHALL be exact equality against the latched n_last, so n_last=2^INPUT_WIDTH-1 terminates without idx wrap-around.
REQ-026 start while busy=1 SHALL be ignored; bound changes after capture SHALL have no effect.
REQ-027 fib_go SHALL never be asserted outside ISSUE; at most one request SHALL be outstanding at a time.
REQ-028 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-029 Latency: start accepted at edge k -> fib_go high in cycle k+1; fib_done seen at edge m -> out_valid high from cycle m+1.
REQ-030 Per-n cost with out_ready held at 1: 3 cycles plus core compute time, plus 1 FINISH cycle per sweep.

Reset
REQ-031 rst=1 SHALL force IDLE and clear busy, fib_go, fib_n, out_valid, out_n, out_result, out_overflow, sweep_done and sweep_overflow to 0, immediately and independent of clk.
REQ-032 Reset mid-sweep SHALL abandon the sweep with no sweep_done pulse; the first start after reset SHALL behave as from power-up.

Verification
REQ-033 Sweep n_first=1, n_last=6 with out_ready=1 -> out_result 0,1,1,2,3,5 for out_n 1..6, all out_overflow=0; then one sweep_done pulse with sweep_overflow=0.
REQ-034 Sweep 25..26 with OUTPUT_WIDTH=16 -> n=25 gives 46368, overflow=0; n=26 gives overflow=1; sweep_overflow=1.
REQ-035 Sweep 3..3 with out_ready low for 10 cycles -> out_valid held, payload stable (n=3, result 1), exactly one transfer, no new fib_go until the transfer.
REQ-036 Sweep n_first=5, n_last=2 -> no fib_go, no out_valid, sweep_done pulse 2 cycles after start, sweep_overflow=0.
REQ-037 Sweep 62..63 -> beats with out_n 62 and 63, terminating without wrap; a start pulse during the sweep is ignored.
REQ-038 Reset asserted while in WAIT -> all outputs 0 immediately; a following sweep 0..0 gives result 0 and one sweep_done.

Source files
------------

// File: rtl/fib_sweep_if.sv
// fib_sweep_if: signal bundle between the sweep controller, the downstream
// Fibonacci core and the result-stream consumer.
//   Core request : fib_go, fib_n            (controller -> core)
//   Core response: fib_result, fib_overflow,
//                  fib_done                 (core -> controller)
//   Result stream: out_valid, out_n, out_result,
//                  out_overflow             (controller -> consumer)
//                  out_ready                (consumer -> controller)
// Modports:
//   master - the sweep controller side
//   slave  - the environment side (core plus stream consumer)
interface fib_sweep_if #(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 16
);
  logic                    fib_go;
  logic [INPUT_WIDTH-1:0]  fib_n;
  logic [OUTPUT_WIDTH-1:0] fib_result;
  logic                    fib_overflow;
  logic                    fib_done;

  logic                    out_valid;
  logic                    out_ready;
  logic [INPUT_WIDTH-1:0]  out_n;
  logic [OUTPUT_WIDTH-1:0] out_result;
  logic                    out_overflow;

  modport master (
    output fib_go, fib_n,
    input  fib_result, fib_overflow, fib_done,
    output out_valid, out_n, out_result, out_overflow,
    input  out_ready
  );

  modport slave (
    input  fib_go, fib_n,
    output fib_result, fib_overflow, fib_done,
    input  out_valid, out_n, out_result, out_overflow,
    output out_ready
  );
endinterface

// File: rtl/fib_sweep.sv
// fib_sweep: walks an index from n_first to n_last (inclusive), asks the
// external Fibonacci core for each index one request at a time, and streams
// every result out over a valid/ready handshake. A one-cycle sweep_done pulse
// with the OR of all per-beat overflow flags closes each sweep.
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start_i            sweep request, sampled only while idle
//   n_first_i/n_last_i inclusive sweep bounds, captured when start is taken
//   busy_o             high whenever the controller is not idle
//   sweep_done_o       one-cycle pulse when a sweep completes
//   sweep_overflow_o   overflow summary of the last sweep
//   bus                fib_sweep_if.master (core request/response + stream)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; bounds captured on start
// ISSUE  | fib_go high for this single cycle with fib_n = idx
// SETTLE | one cycle where a stale fib_done is ignored
// WAIT   | waiting for fib_done, result captured into out_* registers
// EMIT   | out_valid held with stable payload until out_ready
// FINISH | produces sweep_done / sweep_overflow, returns to IDLE
module fib_sweep #(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [INPUT_WIDTH-1:0] n_first_i,
  input  logic [INPUT_WIDTH-1:0] n_last_i,
  output logic                   busy_o,
  output logic                   sweep_done_o,
  output logic                   sweep_overflow_o,
  fib_sweep_if.master            bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT,
    EMIT,
    FINISH
  } state_t;

  state_t                  state_q;
  logic [INPUT_WIDTH-1:0]  idx_q;
  logic [INPUT_WIDTH-1:0]  idx_d;
  logic [INPUT_WIDTH-1:0]  n_last_q;
  logic                    acc_q;

  logic                    busy_q;
  logic                    fib_go_q;
  logic [INPUT_WIDTH-1:0]  fib_n_q;
  logic                    out_valid_q;
  logic [INPUT_WIDTH-1:0]  out_n_q;
  logic [OUTPUT_WIDTH-1:0] out_result_q;
  logic                    out_overflow_q;
  logic                    sweep_done_q;
  logic                    sweep_overflow_q;

  // Only used when idx != n_last, so it can never wrap past the top index.
  assign idx_d = idx_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      n_last_q         <= '0;
      acc_q            <= 1'b0;
      busy_q           <= 1'b0;
      fib_go_q         <= 1'b0;
      fib_n_q          <= '0;
      out_valid_q      <= 1'b0;
      out_n_q          <= '0;
      out_result_q     <= '0;
      out_overflow_q   <= 1'b0;
      sweep_done_q     <= 1'b0;
      sweep_overflow_q <= 1'b0;
    end else begin
      fib_go_q     <= 1'b0;
      sweep_done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            n_last_q         <= n_last_i;
            idx_q            <= n_first_i;
            acc_q            <= 1'b0;
            sweep_overflow_q <= 1'b0;
            busy_q           <= 1'b1;
            if (n_first_i > n_last_i) begin
              state_q <= FINISH;
            end else begin
              // fib_go / fib_n are loaded here so they are visible during ISSUE.
              fib_go_q <= 1'b1;
              fib_n_q  <= n_first_i;
              state_q  <= ISSUE;
            end
          end
        end

        ISSUE: begin
          state_q <= SETTLE;
        end

        // fib_done is a level that only drops a cycle after fib_go, so the
        // previous request's done may still be high here.
        SETTLE: begin
          state_q <= WAIT;
        end

        WAIT: begin
          if (bus.fib_done) begin
            out_n_q        <= idx_q;
            out_result_q   <= bus.fib_result;
            out_overflow_q <= bus.fib_overflow;
            out_valid_q    <= 1'b1;
            state_q        <= EMIT;
          end
        end

        EMIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= acc_q | out_overflow_q;
            if (idx_q == n_last_q) begin
              state_q <= FINISH;
            end else begin
              idx_q    <= idx_d;
              fib_n_q  <= idx_d;
              fib_go_q <= 1'b1;
              state_q  <= ISSUE;
            end
          end
        end

        // sweep_done is registered out of FINISH, so the pulse lands in the
        // cycle after FINISH, together with the final overflow summary.
        FINISH: begin
          sweep_done_q     <= 1'b1;
          sweep_overflow_q <= acc_q;
          busy_q           <= 1'b0;
          state_q          <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign sweep_done_o     = sweep_done_q;
  assign sweep_overflow_o = sweep_overflow_q;

  assign bus.fib_go       = fib_go_q;
  assign bus.fib_n        = fib_n_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_n        = out_n_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_overflow = out_overflow_q;

endmodule

// File: tb/tb_fib_sweep.sv
// tb_fib_sweep: directed bench for fib_sweep. A behavioural Fibonacci core
// (result for index n is F(n-1), F(0)=0, index 0 gives 0) answers requests
// with a programmable latency and keeps fib_done high until one cycle after
// the next fib_go. A monitor logs stream beats, fib_go and sweep_done pulses.
module tb_fib_sweep;
  localparam int IW = 6;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] n_first;
  logic [IW-1:0] n_last;
  logic          busy;
  logic          sweep_done;
  logic          sweep_overflow;

  fib_sweep_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

  fib_sweep #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start),
    .n_first_i        (n_first),
    .n_last_i         (n_last),
    .busy_o           (busy),
    .sweep_done_o     (sweep_done),
    .sweep_overflow_o (sweep_overflow),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fib_ref(input logic [IW-1:0] n);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    if (n == '0) return 64'd0;
    for (int i = 1; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // core model
  int            core_lat = 2;
  int            core_cnt;
  logic          core_busy;
  logic [IW-1:0] core_n;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.fib_done     <= 1'b0;
      bus.fib_result   <= '0;
      bus.fib_overflow <= 1'b0;
      core_busy        <= 1'b0;
      core_cnt         <= 0;
      core_n           <= '0;
    end else if (bus.fib_go) begin
      core_n    <= bus.fib_n;
      core_cnt  <= core_lat;
      core_busy <= 1'b1;
    end else if (core_busy) begin
      bus.fib_done <= 1'b0;
      if (core_cnt == 0) begin
        bus.fib_done     <= 1'b1;
        bus.fib_result   <= OW'(fib_ref(core_n));
        bus.fib_overflow <= (fib_ref(core_n) >> OW) != 64'd0;
        core_busy        <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // monitor
  int          go_cnt    = 0;
  int          done_cnt  = 0;
  int          valid_cnt = 0;
  int          viol      = 0;
  logic        outstanding = 1'b0;
  logic        last_sovf   = 1'b0;
  int          bq_n[$];
  logic [63:0] bq_r[$];
  logic        bq_o[$];

  always @(posedge clk) begin
    if (rst) begin
      outstanding <= 1'b0;
    end else begin
      if (bus.fib_go) begin
        go_cnt <= go_cnt + 1;
        if (outstanding) viol <= viol + 1;
        outstanding <= 1'b1;
      end
      if (bus.out_valid) valid_cnt <= valid_cnt + 1;
      if (bus.out_valid && bus.out_ready) begin
        bq_n.push_back(int'(bus.out_n));
        bq_r.push_back(64'(bus.out_result));
        bq_o.push_back(bus.out_overflow);
        outstanding <= 1'b0;
      end
      if (sweep_done) begin
        done_cnt  <= done_cnt + 1;
        last_sovf <= sweep_overflow;
      end
    end
  end

  task automatic start_sweep(input int f, input int l);
    @(negedge clk);
    n_first = f[IW-1:0];
    n_last  = l[IW-1:0];
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int i;
    i = 0;
    while (done_cnt == base && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 64'(done_cnt - base), 64'd1);
  endtask

  task automatic chk_beat(input int pos, input string tag, input int en, input int er, input logic eo);
    chk({tag, "_present"}, 64'(pos < bq_n.size()), 64'd1);
    if (pos < bq_n.size()) begin
      chk({tag, "_n"},   64'(bq_n[pos]), 64'(en));
      chk({tag, "_res"}, bq_r[pos],      64'(er));
      chk({tag, "_ovf"}, 64'(bq_o[pos]), 64'(eo));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   64'(busy),             64'd0);
    chk({tag, "_go"},     64'(bus.fib_go),       64'd0);
    chk({tag, "_fib_n"},  64'(bus.fib_n),        64'd0);
    chk({tag, "_valid"},  64'(bus.out_valid),    64'd0);
    chk({tag, "_out_n"},  64'(bus.out_n),        64'd0);
    chk({tag, "_result"}, 64'(bus.out_result),   64'd0);
    chk({tag, "_ovf"},    64'(bus.out_overflow), 64'd0);
    chk({tag, "_sdone"},  64'(sweep_done),       64'd0);
    chk({tag, "_sovf"},   64'(sweep_overflow),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int b_go, b_beat, b_done, b_valid, bad, i;
    int exp1[6];
    exp1 = '{0, 1, 1, 2, 3, 5};

    rst           = 1'b1;
    start         = 1'b0;
    n_first       = '0;
    n_last        = '0;
    bus.out_ready = 1'b1;
    #2;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // sweep 1..6
    b_go = go_cnt; b_beat = bq_n.size(); b_done = done_cnt;
    start_sweep(1, 6);
    chk("lat_go",   64'(bus.fib_go), 64'd1);
    chk("lat_fibn", 64'(bus.fib_n),  64'd1);
    chk("lat_busy", 64'(busy),       64'd1);
    wait_done(b_done, "s1_done");
    chk("s1_beats", 64'(bq_n.size() - b_beat), 64'd6);
    for (int k = 0; k < 6; k++) chk_beat(b_beat + k, "s1", k + 1, exp1[k], 1'b0);
    chk("s1_sovf", 64'(last_sovf), 64'd0);
    chk("s1_go",   64'(go_cnt - b_go), 64'd6);

    // sweep 25..26, overflow at 26
    b_go = go_cnt; b_beat = bq_n.size(); b_done = done_cnt;
    start_sweep(25, 26);
    wait_done(b_done, "s2_done");
    chk("s2_beats", 64'(bq_n.size() - b_beat), 64'd2);
    chk_beat(b_beat, "s2_25", 25, 46368, 1'b0);
    chk("s2_26_present", 64'(b_beat + 1 < bq_n.size()), 64'd1);
    if (b_beat + 1 < bq_n.size()) begin
      chk("s2_26_n",   64'(bq_n[b_beat + 1]), 64'd26);
      chk("s2_26_ovf", 64'(bq_o[b_beat + 1]), 64'd1);
    end
    chk("s2_sovf", 64'(last_sovf), 64'd1);

    // sweep 5..2, empty
    b_go = go_cnt; b_done = done_cnt; b_valid = valid_cnt;
    start_sweep(5, 2);
    chk("s4_done_k1", 64'(sweep_done), 64'd0);
    chk("s4_busy_k1", 64'(busy),       64'd1);
    @(negedge clk);
    chk("s4_done_k2", 64'(sweep_done),     64'd1);
    chk("s4_sovf",    64'(sweep_overflow), 64'd0);
    chk("s4_busy_k2", 64'(busy),           64'd0);
    @(negedge clk);
    chk("s4_pulse_end", 64'(sweep_done), 64'd0);
    chk("s4_go",        64'(go_cnt - b_go),       64'd0);
    chk("s4_valid",     64'(valid_cnt - b_valid), 64'd0);
    chk("s4_count",     64'(done_cnt - b_done),   64'd1);

    // sweep 3..3 with backpressure
    b_go = go_cnt; b_beat = bq_n.size(); b_done = done_cnt;
    bus.out_ready = 1'b0;
    start_sweep(3, 3);
    i = 0;
    while (bus.out_valid !== 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("s3_valid", 64'(bus.out_valid), 64'd1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(bus.out_valid === 1'b1 && bus.out_n === 6'd3 && bus.out_result === 16'd1)) bad++;
    end
    chk("s3_hold",    64'(bad), 64'd0);
    chk("s3_go_hold", 64'(go_cnt - b_go), 64'd1);
    chk("s3_nobeat",  64'(bq_n.size() - b_beat), 64'd0);
    bus.out_ready = 1'b1;
    wait_done(b_done, "s3_done");
    chk("s3_beats", 64'(bq_n.size() - b_beat), 64'd1);
    chk_beat(b_beat, "s3", 3, 1, 1'b0);
    chk("s3_go", 64'(go_cnt - b_go), 64'd1);

    // sweep 62..63 with an ignored start mid-sweep
    b_go = go_cnt; b_beat = bq_n.size(); b_done = done_cnt;
    start_sweep(62, 63);
    repeat (2) @(negedge clk);
    chk("s5_busy_mid", 64'(busy), 64'd1);
    n_first = '0;
    n_last  = '0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_done(b_done, "s5_done");
    chk("s5_beats", 64'(bq_n.size() - b_beat), 64'd2);
    chk("s5_n62_present", 64'(b_beat + 1 < bq_n.size()), 64'd1);
    if (b_beat + 1 < bq_n.size()) begin
      chk("s5_n62", 64'(bq_n[b_beat]),     64'd62);
      chk("s5_n63", 64'(bq_n[b_beat + 1]), 64'd63);
      chk("s5_o62", 64'(bq_o[b_beat]),     64'd1);
      chk("s5_o63", 64'(bq_o[b_beat + 1]), 64'd1);
    end
    chk("s5_sovf", 64'(last_sovf), 64'd1);
    repeat (10) @(negedge clk);
    chk("s5_idle",  64'(busy), 64'd0);
    chk("s5_go",    64'(go_cnt - b_go),     64'd2);
    chk("s5_count", 64'(done_cnt - b_done), 64'd1);

    // reset while in WAIT, then sweep 0..0
    core_lat = 8;
    b_done = done_cnt;
    start_sweep(10, 12);
    @(negedge clk);
    @(negedge clk);
    chk("s6_busy_pre", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("s6_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    core_lat = 2;
    repeat (3) @(negedge clk);
    chk("s6_no_done", 64'(done_cnt - b_done), 64'd0);
    b_go = go_cnt; b_beat = bq_n.size(); b_done = done_cnt;
    start_sweep(0, 0);
    wait_done(b_done, "s6_done");
    chk("s6_beats", 64'(bq_n.size() - b_beat), 64'd1);
    chk_beat(b_beat, "s6", 0, 0, 1'b0);
    chk("s6_go", 64'(go_cnt - b_go), 64'd1);

    chk("one_outstanding", 64'(viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
